viterbi_channel_err: RTL and testbench
======================================

# viterbi_channel_err

Parametrised, synthesizable noisy-channel model that sits between the convolutional encoder and the Viterbi decoder. It passes SYM_W-bit encoded symbols through with one cycle of latency. Inside a configurable observation window it XORs pseudo-random error masks onto those symbols, either as isolated events or as fixed-length bursts. It also counts injected error events and corrupted bits, so benches can correlate decoder output quality with channel bit error rate (BER).

## Interface
Parameters:
- SYM_W, 2, symbol width in bits (1..8)
- N, 4, error-rate control; trigger probability per symbol is 2^-N (1..16)
- BURST_LEN, 4, symbols corrupted per event in burst mode (1..255)
- WINDOW, 256, accepted symbols during which injection is allowed (1..65535)
- SEED, 32'hACE1_2468, LFSR reset value (must be nonzero)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- mode_i  in  2  0 = clean, 1 = random, 2 = burst, 3 = clean (reserved)
- valid_i  in  1  sym_i is valid this cycle
- sym_i  in  SYM_W  encoder output symbol
- valid_o  out  1  registered valid_i
- sym_o  out  SYM_W  symbol after error injection
- err_mask_o  out  SYM_W  mask applied to the symbol on sym_o
- window_done_o  out  1  high once WINDOW symbols have been accepted
- err_event_ct_o  out  16  count of symbols with a nonzero mask, saturating
- bad_bit_ct_o  out  16  count of flipped bits, saturating (see Configuration)

## Operation
- LFSR: 32-bit Galois, polynomial 0x80200003, reset to SEED. Advances only on cycles with valid_i=1.
- Trigger: lfsr[N-1:0] == 1, evaluated on the pre-advance value.
- Candidate mask: lfsr[N+SYM_W-1:N]. If that value is all-zero, the mask is 1 instead, so every corrupted symbol flips at least one bit.
- Symbol counter sym_ct: increments on each valid_i and saturates at WINDOW. Injection is enabled only while sym_ct < WINDOW.
- window_done_o = (sym_ct == WINDOW).
- Mode 0/3: mask is always 0. The FSM is forced to IDLE.
- Mode 1 (random): each valid symbol with the trigger set and injection enabled gets the mask. There is no burst state.
- Mode 2 (burst), FSM with states IDLE and BURST:
  - IDLE + valid + trigger + enabled: corrupt this symbol. Load burst_left = BURST_LEN-1. Go to BURST if burst_left > 0.
  - BURST + valid: corrupt this symbol with a fresh mask, regardless of trigger. Decrement burst_left. Return to IDLE at 0.
  - BURST with valid_i=0: hold state.
  - Window reaches WINDOW mid-burst: the burst terminates and the FSM returns to IDLE. No further corruption.
  - mode_i leaves 2 mid-burst: return to IDLE on the next cycle. The symbol in that cycle follows the new mode.
- Counters, updated for each valid output symbol:
  - err_event_ct increments by 1 when the mask is nonzero.
  - bad_bit_ct increments by popcount(mask).
  - Both saturate at 16'hFFFF.

## Timing
- Latency is 1 cycle: on the edge after valid_i=1, valid_o=1, sym_o = sym_i ^ mask, err_mask_o = mask.
- When valid_i=0: valid_o=0 next cycle; sym_o and err_mask_o hold their previous values; LFSR, FSM and counters hold.
- Counters and window_done_o reflect the symbol currently on sym_o, i.e. they update in the same edge.
- Reset, asynchronous, valid at any time including mid-burst:
  - valid_o, sym_o, err_mask_o, window_done_o, both counters: 0
  - sym_ct, burst_left: 0
  - FSM: IDLE
  - LFSR: SEED
- No backpressure: every valid_i symbol is accepted.

## Configuration
- VITERBI_CHAN_STATS_EN defined: the popcount adder and bad_bit_ct are implemented and drive bad_bit_ct_o.
- VITERBI_CHAN_STATS_EN not defined: no popcount or bad_bit_ct logic is built. bad_bit_ct_o is tied to 0 and the port is kept.
- err_event_ct_o is always present.

## Test plan
- Clean: mode 0, 300 valid symbols with random data. sym_o equals sym_i delayed by one cycle, err_mask_o=0, both counters 0, window_done_o goes high after symbol 256.
- Random: mode 1, N=1, SEED default, 256 symbols. sym_o ^ sym_i matches a bit-exact LFSR reference model. err_event_ct_o ≈ 128 (±20). bad_bit_ct_o equals the sum of reference popcounts.
- Burst: mode 2, BURST_LEN=4, N=3. Every event corrupts exactly 4 consecutive valid symbols. err_event_ct_o is a multiple of 4 except when a burst is truncated at the window boundary.
- Window edge: WINDOW=8, mode 1, N=1, 20 symbols. No nonzero mask after the 8th symbol. window_done_o rises with symbol 8 and stays high.
- Valid gaps: mode 2, valid_i toggling 1/0 mid-burst. The LFSR and burst_left hold during gaps; the burst still spans 4 valid symbols.
- Reset mid-burst: assert rst in BURST state. Outputs and counters go to 0 immediately. After release, the first mask sequence equals the sequence seen from a cold start.

Source files
------------

// File: rtl/viterbi_channel_err.sv
// viterbi_channel_err
// Noisy-channel model placed between a convolutional encoder and a Viterbi
// decoder. Symbols pass through with one cycle of latency; inside an
// observation window of WINDOW accepted symbols, pseudo-random error masks
// are XORed onto them, either as isolated events (mode 1) or as bursts of
// BURST_LEN consecutive valid symbols (mode 2).
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   mode_i[1:0]     0/3 clean, 1 random, 2 burst
//   valid_i, sym_i  input symbol and its qualifier
//   valid_o, sym_o  registered qualifier and corrupted symbol
//   err_mask_o      mask applied to the symbol on sym_o
//   window_done_o   high once WINDOW symbols have been accepted
//   err_event_ct_o  saturating count of symbols with a nonzero mask
//   bad_bit_ct_o    saturating count of flipped bits
//
// Optional feature macro: VITERBI_CHAN_STATS_EN builds the popcount adder
// and the flipped-bit counter; without it bad_bit_ct_o is tied to zero.
//
// Handshake: valid_i is a one-way qualifier with no backpressure; every
// symbol presented with valid_i=1 is accepted on that rising edge.

module viterbi_channel_err #(
    parameter int          SYM_W     = 2,
    parameter int          N         = 4,
    parameter int          BURST_LEN = 4,
    parameter int          WINDOW    = 256,
    parameter logic [31:0] SEED      = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_i,
    input  logic             valid_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic             valid_o,
    output logic [SYM_W-1:0] sym_o,
    output logic [SYM_W-1:0] err_mask_o,
    output logic             window_done_o,
    output logic [15:0]      err_event_ct_o,
    output logic [15:0]      bad_bit_ct_o
);

    localparam logic [31:0] POLY  = 32'h8020_0003;
    localparam logic [15:0] WIN   = 16'(WINDOW);
    localparam logic [7:0]  BL_M1 = 8'(BURST_LEN - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_lfsr;
    logic [31:0]      w_lfsr_nxt;
    logic [15:0]      r_sym_ct;
    logic [15:0]      w_sym_ct_nxt;
    logic [7:0]       r_burst_left, w_burst_left_nxt;
    logic             w_trig, w_en, w_hit;
    logic [SYM_W-1:0] w_field, w_cand, w_mask;

    logic             r_valid_o;
    logic [SYM_W-1:0] r_sym_o, r_err_mask_o;
    logic             r_window_done;
    logic [15:0]      r_err_event_ct;

    // Trigger and candidate mask both come from the pre-advance LFSR value.
    assign w_trig  = (r_lfsr[N-1:0] == N'(1));
    assign w_field = r_lfsr[N+SYM_W-1:N];
    // An all-zero candidate becomes 1 so a corrupted symbol always flips a bit.
    assign w_cand  = (w_field == '0) ? SYM_W'(1) : w_field;
    assign w_en    = (r_sym_ct < WIN);

    // Right-shifting Galois LFSR: the bit shifted out selects the tap XOR.
    assign w_lfsr_nxt   = r_lfsr[0] ? ((r_lfsr >> 1) ^ POLY) : (r_lfsr >> 1);
    assign w_sym_ct_nxt = (r_sym_ct == WIN) ? r_sym_ct : (r_sym_ct + 16'd1);

    always_comb begin
        w_state_nxt      = r_state;
        w_burst_left_nxt = r_burst_left;
        w_hit            = 1'b0;
        case (mode_i)
            2'd1: begin
                w_state_nxt      = ST_IDLE;
                w_burst_left_nxt = 8'd0;
                w_hit            = valid_i && w_trig && w_en;
            end
            2'd2: begin
                case (r_state)
                    ST_IDLE: begin
                        if (valid_i && w_trig && w_en) begin
                            w_hit            = 1'b1;
                            w_burst_left_nxt = BL_M1;
                            if (BL_M1 != 8'd0) w_state_nxt = ST_BURST;
                        end
                    end
                    ST_BURST: begin
                        if (!w_en) begin
                            // Window closed mid-burst: abandon the burst.
                            w_state_nxt      = ST_IDLE;
                            w_burst_left_nxt = 8'd0;
                        end else if (valid_i) begin
                            // Burst symbols ignore the trigger.
                            w_hit            = 1'b1;
                            w_burst_left_nxt = r_burst_left - 8'd1;
                            if (r_burst_left == 8'd1) w_state_nxt = ST_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt      = ST_IDLE;
                        w_burst_left_nxt = 8'd0;
                    end
                endcase
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_burst_left_nxt = 8'd0;
            end
        endcase
    end

    assign w_mask = w_hit ? w_cand : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_burst_left   <= 8'd0;
            r_lfsr         <= SEED;
            r_sym_ct       <= 16'd0;
            r_valid_o      <= 1'b0;
            r_sym_o        <= '0;
            r_err_mask_o   <= '0;
            r_window_done  <= 1'b0;
            r_err_event_ct <= 16'd0;
        end else begin
            r_valid_o    <= valid_i;
            r_state      <= w_state_nxt;
            r_burst_left <= w_burst_left_nxt;
            if (valid_i) begin
                r_lfsr        <= w_lfsr_nxt;
                r_sym_ct      <= w_sym_ct_nxt;
                r_sym_o       <= sym_i ^ w_mask;
                r_err_mask_o  <= w_mask;
                r_window_done <= (w_sym_ct_nxt == WIN);
                if ((w_mask != '0) && (r_err_event_ct != 16'hFFFF))
                    r_err_event_ct <= r_err_event_ct + 16'd1;
            end
        end
    end

`ifdef VITERBI_CHAN_STATS_EN
    logic [3:0]  w_pop;
    logic [16:0] w_bad_sum;
    logic [15:0] r_bad_bit_ct;

    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < SYM_W; i++) w_pop = w_pop + 4'(w_mask[i]);
    end

    assign w_bad_sum = {1'b0, r_bad_bit_ct} + 17'(w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bad_bit_ct <= 16'd0;
        end else if (valid_i) begin
            r_bad_bit_ct <= w_bad_sum[16] ? 16'hFFFF : w_bad_sum[15:0];
        end
    end

    assign bad_bit_ct_o = r_bad_bit_ct;
`else
    assign bad_bit_ct_o = 16'd0;
`endif

    assign valid_o        = r_valid_o;
    assign sym_o          = r_sym_o;
    assign err_mask_o     = r_err_mask_o;
    assign window_done_o  = r_window_done;
    assign err_event_ct_o = r_err_event_ct;

endmodule

// File: tb/tb_viterbi_channel_err.sv
// tb_viterbi_channel_err
// Directed bench for viterbi_channel_err with a behavioural channel model.
// The model is stepped by the driver on each negative edge; the compare
// process checks every output on every cycle 2 time units after the rising
// edge. Literal mask sequences worked out by hand from SEED pin the model.

module tb_viterbi_channel_err;

    localparam int          SYM_W     = 2;
    localparam int          N         = 2;
    localparam int          BURST_LEN = 4;
    localparam int          WINDOW    = 24;
    localparam logic [31:0] SEED      = 32'hACE1_2468;
    localparam int          W         = 2 + 2 * SYM_W + 32;
`ifdef VITERBI_CHAN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       mode_i = 2'd0;
    logic             valid_i = 1'b0;
    logic [SYM_W-1:0] sym_i = '0;
    logic             valid_o;
    logic [SYM_W-1:0] sym_o, err_mask_o;
    logic             window_done_o;
    logic [15:0]      err_event_ct_o, bad_bit_ct_o;

    viterbi_channel_err #(
        .SYM_W(SYM_W), .N(N), .BURST_LEN(BURST_LEN), .WINDOW(WINDOW), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .mode_i(mode_i), .valid_i(valid_i), .sym_i(sym_i),
        .valid_o(valid_o), .sym_o(sym_o), .err_mask_o(err_mask_o),
        .window_done_o(window_done_o), .err_event_ct_o(err_event_ct_o),
        .bad_bit_ct_o(bad_bit_ct_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0]     exp_q[$];
    logic [SYM_W-1:0] obs_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- channel model ----------------
    logic [31:0]      m_lfsr;
    int               m_ct, m_burst, m_ev, m_bb;
    logic             e_valid, e_done;
    logic [SYM_W-1:0] e_sym, e_mask;

    function automatic logic [W-1:0] pack_exp();
        logic [15:0] bb;
        bb = STATS ? 16'(m_bb) : 16'd0;
        return {e_valid, e_sym, e_mask, e_done, 16'(m_ev), bb};
    endfunction

    task automatic model_reset();
        m_lfsr = SEED; m_ct = 0; m_burst = 0; m_ev = 0; m_bb = 0;
        e_valid = 1'b0; e_done = 1'b0; e_sym = '0; e_mask = '0;
    endtask

    task automatic model_step(input logic v, input logic [SYM_W-1:0] s, input logic [1:0] m);
        bit en, trig, corrupt;
        int cand;
        e_valid = v;
        if (v) begin
            en      = (m_ct < WINDOW);
            trig    = ((m_lfsr % (1 << N)) == 1);
            cand    = int'((m_lfsr >> N) % (1 << SYM_W));
            if (cand == 0) cand = 1;
            corrupt = 1'b0;
            if (m == 2'd1) begin
                corrupt = trig && en;
            end else if (m == 2'd2) begin
                if (m_burst > 0 && en) begin
                    corrupt = 1'b1;
                    m_burst--;
                end else if (en && trig) begin
                    corrupt = 1'b1;
                    m_burst = BURST_LEN - 1;
                end
            end
            if (!en) m_burst = 0;
            e_mask = corrupt ? SYM_W'(cand) : '0;
            e_sym  = s ^ e_mask;
            if (corrupt && m_ev < 65535) m_ev++;
            m_bb = m_bb + $countones(e_mask);
            if (m_bb > 65535) m_bb = 65535;
            if (m_ct < WINDOW) m_ct++;
            e_done = (m_ct == WINDOW);
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
        end
        if (m != 2'd2) m_burst = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [1:0] m);
        logic [SYM_W-1:0] s;
        s = SYM_W'($urandom_range(0, (1 << SYM_W) - 1));
        @(negedge clk);
        valid_i = v; sym_i = s; mode_i = m;
        model_step(v, s, m);
        exp_q.push_back(pack_exp());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
    endtask

    task automatic check_masks(input string name, input logic [SYM_W-1:0] lit[8]);
        @(negedge clk);
        valid_i = 1'b0;
        model_step(1'b0, '0, mode_i);
        exp_q.push_back(pack_exp());
        @(negedge clk);
        check({name, "_len"}, 32'(obs_q.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < obs_q.size(); i++)
            check($sformatf("%s_mask%0d", name, i), 32'(obs_q[i]), 32'(lit[i]));
    endtask

    // ---------------- compare process ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid_o", 32'(valid_o), 32'(e[W-1]));
                check("sym_o", 32'(sym_o), 32'(e[W-2 -: SYM_W]));
                check("err_mask_o", 32'(err_mask_o), 32'(e[W-2-SYM_W -: SYM_W]));
                check("window_done_o", 32'(window_done_o), 32'(e[32]));
                check("err_event_ct_o", 32'(err_event_ct_o), 32'(e[31:16]));
                check("bad_bit_ct_o", 32'(bad_bit_ct_o), 32'(e[15:0]));
                if (valid_o) obs_q.push_back(err_mask_o);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [SYM_W-1:0] lit_rand[8]  = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd0, 2'd0};
    logic [SYM_W-1:0] lit_burst[8] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd1, 2'd0};
    logic [SYM_W-1:0] lit_switch[8] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd0, 2'd0};

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        // Reset state while rst is held.
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_sym_o", 32'(sym_o), 32'd0);
        check("rst_mask", 32'(err_mask_o), 32'd0);
        check("rst_done", 32'(window_done_o), 32'd0);
        check("rst_ev", 32'(err_event_ct_o), 32'd0);
        check("rst_bb", 32'(bad_bit_ct_o), 32'd0);
        rst = 1'b0;

        // Random mode from cold start; runs past the window edge.
        for (int i = 0; i < 8; i++) drive(1'b1, 2'd1);
        check_masks("random_cold", lit_rand);
        for (int i = 0; i < 22; i++) drive(1'b1, 2'd1);
        @(negedge clk);
        check("random_window_done", 32'(window_done_o), 32'd1);

        // Clean modes 0 and 3.
        do_reset();
        for (int i = 0; i < 30; i++) drive(1'b1, 2'd0);
        for (int i = 0; i < 6; i++) drive(1'b1, 2'd3);
        @(negedge clk);
        check("clean_ev", 32'(err_event_ct_o), 32'd0);
        check("clean_done", 32'(window_done_o), 32'd1);

        // Burst mode from cold start, then through the window edge.
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 2'd2);
        check_masks("burst_cold", lit_burst);
        check("burst_ev_lit", 32'(err_event_ct_o), 32'd4);
        for (int i = 0; i < 40; i++) drive(1'($urandom_range(0, 1)), 2'd2);

        // Valid gaps inside the burst leave the sequence unchanged.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 2'd2);
        for (int i = 0; i < 8; i++) drive(1'(i % 2), 2'd2);
        drive(1'b0, 2'd2);
        drive(1'b1, 2'd2);
        check_masks("burst_gaps", lit_burst);

        // Mode leaves burst mid-burst.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 2'd2);
        for (int i = 0; i < 2; i++) drive(1'b1, 2'd1);
        drive(1'b1, 2'd2);
        check_masks("mode_switch", lit_switch);

        // Asynchronous reset while a burst is in progress.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 2'd2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        valid_i = 1'b0;
        model_reset();
        #1;
        check("async_valid_o", 32'(valid_o), 32'd0);
        check("async_sym_o", 32'(sym_o), 32'd0);
        check("async_mask", 32'(err_mask_o), 32'd0);
        check("async_ev", 32'(err_event_ct_o), 32'd0);
        check("async_bb", 32'(bad_bit_ct_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        for (int i = 0; i < 8; i++) drive(1'b1, 2'd2);
        check_masks("after_reset", lit_burst);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
